// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous pulse train in clk cycles.
// One result per input period; a sticky flag reports inputs that stop or are too slow.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             level,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] shadow, shadow_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic             valid_nxt, stuck_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    // Synchroniser stage: s1/s2 resolve metastability, s3 is the previous level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

    // Measurement stage: counter runs relative to the last accepted rise
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        period_nxt = period;
        high_nxt   = high_time;
        valid_nxt  = 1'b0;
        stuck_nxt  = stuck;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    cnt_nxt   = ONE;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                cnt_nxt = sat_inc(cnt);
                if (fall) begin
                    shadow_nxt = cnt;
                    state_nxt  = LOW;
                end else if (cnt == MAX) begin
                    stuck_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    period_nxt = cnt;
                    high_nxt   = shadow;
                    valid_nxt  = 1'b1;
                    stuck_nxt  = 1'b0;
                    cnt_nxt    = ONE;
                    state_nxt  = HIGH;
                end else if (cnt == MAX) begin
                    stuck_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Result stage: period/high_time publish together with the valid pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            period    <= period_nxt;
            high_time <= high_nxt;
            valid     <= valid_nxt;
            stuck     <= stuck_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: pin edge times feed a reference model,
// a negedge monitor compares each published measurement against it.
module tb_pwm_capture;

    localparam int     CNT_W = 16;
    localparam longint MAX   = 65535;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_in = 1'b0;
    logic             level;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             stuck;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .level     (level),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    int     total   = 0;
    int     bad     = 0;
    int     n_valid = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint p;
        longint h;
    } meas_t;

    meas_t  exp_q[$];
    bit     armed     = 1'b0;
    bit     fall_seen = 1'b0;
    longint last_rise = 0;
    longint fall_t    = 0;
    longint exp_p     = 0;
    longint exp_h     = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a measurement spans two rises whose gap fits in MAX cycles
    task automatic model_edge(input logic b, input longint t);
        if (armed && (t - last_rise) > MAX)
            armed = 1'b0;
        if (b) begin
            if (armed && fall_seen)
                exp_q.push_back('{t - last_rise, fall_t - last_rise});
            armed     = 1'b1;
            last_rise = t;
            fall_seen = 1'b0;
        end else if (armed) begin
            fall_seen = 1'b1;
            fall_t    = t;
        end
    endtask

    task automatic model_reset();
        armed     = 1'b0;
        fall_seen = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input logic b, input int n);
        if (b !== pwm_in) begin
            pwm_in = b;
            if (rst)
                model_edge(b, cyc);
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    always @(negedge clk) begin : monitor
        meas_t m;
        if (!rst) begin
            exp_p = 0;
            exp_h = 0;
            check("reset_outputs", {level, period, high_time, valid, stuck}, 0);
        end else if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                m = exp_q.pop_front();
                check("period", period, m.p);
                check("high_time", high_time, m.h);
                exp_p = m.p;
                exp_h = m.h;
            end
            check("stuck_at_valid", stuck, 0);
        end else begin
            check("hold_period", period, exp_p);
            check("hold_high_time", high_time, exp_h);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv0;
        int h;
        int l;

        // Reset with the pin low; no measurement may appear while idle
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_state", {level, period, high_time, valid, stuck}, 0);
        rst = 1'b1;
        drive(1'b0, 100);
        check("idle_valid_count", n_valid, 0);
        check("idle_stuck", stuck, 0);
        check("idle_level", level, 0);

        // 10/30 square wave
        nv0 = n_valid;
        wave(10, 30, 6);
        check("sq_valid_count", n_valid - nv0, 5);
        check("sq_stuck", stuck, 0);
        check("sq_period", period, 40);
        check("sq_high_time", high_time, 10);

        // 1-cycle pulse every 5 cycles
        wave(1, 4, 8);
        check("pulse_period", period, 5);
        check("pulse_high_time", high_time, 1);

        // Change of wave at a period boundary
        wave(10, 30, 3);
        wave(25, 25, 3);
        check("chg_period", period, 50);
        check("chg_high_time", high_time, 25);

        // Random duty and period
        for (int i = 0; i < 150; i++) begin
            h = $urandom_range(1, 20);
            l = $urandom_range(1, 20);
            wave(h, l, 1);
        end
        wave(10, 30, 2);
        check("rand_stuck", stuck, 0);

        // Reset asserted mid-HIGH, released while the pin is low
        drive(1'b1, 5);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {period, high_time, valid, stuck, level}, 0);
        check("queue_empty_at_reset", exp_q.size(), 0);
        model_reset();
        drive(1'b1, 5);
        drive(1'b0, 20);
        rst = 1'b1;
        drive(1'b0, 10);
        nv0 = n_valid;
        wave(10, 30, 1);
        check("post_reset_first_rise_no_valid", n_valid - nv0, 0);
        wave(10, 30, 2);
        check("post_reset_period", period, 40);
        check("post_reset_high_time", high_time, 10);

        // Pin stuck high past the counter range
        drive(1'b1, 65520);
        check("stuck_before_max", stuck, 0);
        drive(1'b1, 70000 - 65520);
        check("stuck_after_max", stuck, 1);
        check("stuck_level", level, 1);
        check("stuck_keeps_period", period, 40);
        check("stuck_keeps_high_time", high_time, 10);
        drive(1'b0, 30);
        drive(1'b1, 10);
        check("stuck_not_cleared_by_rise", stuck, 1);
        drive(1'b0, 30);
        wave(10, 30, 1);
        check("stuck_cleared_by_valid", stuck, 0);
        check("resume_period", period, 40);
        check("resume_high_time", high_time, 10);

        drive(1'b0, 20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
